// File: rtl/pdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pdm_pkg
// Description : Shared types and default constants for the PDM capture path.
// Revision    : 1.0 - initial release
// ============================================================================
package pdm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } pdm_state_t;

    localparam int PDM_CLK_DIV  = 8;
    localparam int PDM_WARM_CYC = 1024;
    localparam int PDM_WARM_W   = 16;

endpackage
`default_nettype wire

// File: rtl/pdm_sync2.sv
`default_nettype none
// ============================================================================
// Module      : pdm_sync2
// Description : Two-flop synchroniser for the asynchronous mic data pin.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            q      <= 1'b0;
        end else begin
            r_meta <= d;
            q      <= r_meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pdm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pdm_capture
// Description : PDM bit-clock generator, pin synchroniser and L/R splitter.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_capture
    import pdm_pkg::*;
#(
    parameter int CLK_DIV  = PDM_CLK_DIV,
    parameter int L_PHASE  = CLK_DIV/2 - 1,
    parameter int R_PHASE  = CLK_DIV - 1,
    parameter int WARM_CYC = PDM_WARM_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic pdm_data,
    output logic pdm_clk,
    output logic we,
    output logic data_l,
    output logic data_r,
    output logic ready
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0]         C_LAST      = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]         C_HALF      = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0]         C_L         = CW'(L_PHASE);
    localparam logic [PDM_WARM_W-1:0] C_WARM      = PDM_WARM_W'(WARM_CYC);
    localparam logic [PDM_WARM_W-1:0] C_WARM_LAST = PDM_WARM_W'(WARM_CYC - 1);

    pdm_state_t            r_state;
    pdm_state_t            w_state_nxt;
    logic [CW-1:0]         r_div_cnt;
    logic [CW-1:0]         w_div_nxt;
    logic [PDM_WARM_W-1:0] r_warm;
    logic                  r_l_hold;
    logic                  w_sync;
    logic                  w_wrap;
    logic                  w_active;
    logic                  w_strobe;

    pdm_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pdm_data),
        .q   (w_sync)
    );

    assign w_wrap   = (r_div_cnt == C_LAST);
    assign w_active = en && (r_state != IDLE);
    assign w_strobe = en && (r_state == RUN) && w_wrap;
    assign ready    = (r_state == RUN);

    // Leaving IDLE restarts the divider so the enabling edge begins period 0.
    assign w_div_nxt = ((r_state == IDLE) || w_wrap) ? '0 : r_div_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (en)
                    w_state_nxt = WARMUP;
            end
            WARMUP: begin
                if (!en)
                    w_state_nxt = IDLE;
                else if (w_wrap && (r_warm == C_WARM_LAST))
                    w_state_nxt = RUN;
            end
            RUN: begin
                if (!en)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= C_LAST;
            r_warm    <= '0;
            pdm_clk   <= 1'b0;
            we        <= 1'b0;
            data_l    <= 1'b0;
            r_l_hold  <= 1'b0;
        end else begin
            we <= 1'b0;
            if (!en) begin
                r_div_cnt <= C_LAST;
                r_warm    <= '0;
                pdm_clk   <= 1'b0;
            end else begin
                r_div_cnt <= w_div_nxt;
                pdm_clk   <= (w_div_nxt < C_HALF);
                if ((r_state == WARMUP) && w_wrap && (r_warm != C_WARM))
                    r_warm <= r_warm + 1'b1;
            end
            if (w_active && (r_div_cnt == C_L))
                r_l_hold <= w_sync;
            if (w_strobe) begin
                data_l <= r_l_hold;
                we     <= 1'b1;
            end
        end
    end

    // With the right phase on the last count, the sample goes straight out on the wrap edge.
    generate
        if (R_PHASE == CLK_DIV - 1) begin : g_r_direct
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    data_r <= 1'b0;
                else if (w_strobe)
                    data_r <= w_sync;
            end
        end else begin : g_r_hold
            localparam logic [CW-1:0] C_R = CW'(R_PHASE);
            logic r_r_hold;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_r_hold <= 1'b0;
                    data_r   <= 1'b0;
                end else begin
                    if (w_active && (r_div_cnt == C_R))
                        r_r_hold <= w_sync;
                    if (w_strobe)
                        data_r <= r_r_hold;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pdm_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdm_capture
// Description : Randomised scoreboard bench for pdm_capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdm_capture;

    localparam int CLK_DIV  = 8;
    localparam int L_PHASE  = 3;
    localparam int R_PHASE  = 7;
    localparam int WARM_CYC = 4;
    localparam int HALF     = CLK_DIV / 2;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic en       = 1'b0;
    logic pdm_data = 1'b0;
    logic pdm_clk, we, data_l, data_r, ready;

    pdm_capture #(
        .CLK_DIV  (CLK_DIV),
        .L_PHASE  (L_PHASE),
        .R_PHASE  (R_PHASE),
        .WARM_CYC (WARM_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .pdm_data (pdm_data),
        .pdm_clk  (pdm_clk),
        .we       (we),
        .data_l   (data_l),
        .data_r   (data_r),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic dl;
        logic dr;
        bit   chk;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   async_on = 1'b0;
    logic pin_mem [0:4095];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cycle %0d got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t it;
        if (mon_en) begin
            checks++;
            if ($isunknown({pdm_clk, we, data_l, data_r, ready})) begin
                errors++;
                $display("FAIL no_x: cycle %0d outputs %b%b%b%b%b", cyc, pdm_clk, we, data_l, data_r, ready);
            end
            if (we === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL we_unexpected: strobe at cycle %0d, none expected", cyc);
                end else begin
                    it = exp_q.pop_front();
                    if ((it.cyc != cyc) || (it.chk && ((data_l !== it.dl) || (data_r !== it.dr)))) begin
                        errors++;
                        $display("FAIL we_data: got cycle %0d l=%b r=%b expected cycle %0d l=%b r=%b",
                                 cyc, data_l, data_r, it.cyc, it.dl, it.dr);
                    end
                end
            end
        end
    end

    // Free-running pin toggler for the asynchronous-edge session.
    initial begin
        forever begin
            #($urandom_range(1, 13));
            if (async_on)
                pdm_data = 1'($urandom_range(0, 1));
        end
    end

    // mode: 0 follow pdm_clk, 1 inverted, 2 held high, 3 random per cycle, 4 asynchronous
    task automatic session(input int mode, input int n_we, input bit use_reset);
        int   c0, e, a, k;
        exp_t it;
        c0 = cyc;
        e  = c0 + 1;
        a  = e + CLK_DIV * (WARM_CYC + 1) + CLK_DIV * (n_we - 1) + 3;
        for (int n = c0; n <= a + 1; n++) begin
            case (mode)
                0:       pin_mem[n] = (n >= e) && (((n - e) % CLK_DIV) < HALF);
                1:       pin_mem[n] = !((n >= e) && (((n - e) % CLK_DIV) < HALF));
                2:       pin_mem[n] = 1'b1;
                default: pin_mem[n] = 1'($urandom_range(0, 1));
            endcase
        end
        for (int j = 0; j < n_we; j++) begin
            k      = e + CLK_DIV * (WARM_CYC + 1 + j);
            it.cyc = k;
            it.dl  = pin_mem[k - CLK_DIV + L_PHASE - 2];
            it.dr  = pin_mem[k - CLK_DIV + R_PHASE - 2];
            it.chk = (mode != 4);
            exp_q.push_back(it);
        end
        async_on = (mode == 4);
        rst = 1'b1;
        en  = 1'b1;
        for (int n = c0; n <= a; n++) begin
            if (n != c0) @(negedge clk);
            if (mode != 4) pdm_data = pin_mem[n];
            if (n < e) begin
                chk1("idle_pdm_clk", pdm_clk, 1'b0);
                chk1("idle_ready", ready, 1'b0);
            end else begin
                chk1("pdm_clk_shape", pdm_clk, ((n - e) % CLK_DIV) < HALF);
                chk1("ready_timing", ready, (n - e) >= CLK_DIV * WARM_CYC);
            end
        end
        if (use_reset) begin
            #1 rst = 1'b0;
            #1;
            chk1("rst_pdm_clk", pdm_clk, 1'b0);
            chk1("rst_we", we, 1'b0);
            chk1("rst_data_l", data_l, 1'b0);
            chk1("rst_data_r", data_r, 1'b0);
            chk1("rst_ready", ready, 1'b0);
        end else begin
            en = 1'b0;
            @(negedge clk);
            chk1("drop_pdm_clk", pdm_clk, 1'b0);
            chk1("drop_ready", ready, 1'b0);
            chk1("drop_we", we, 1'b0);
        end
        async_on = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        chk1("init_pdm_clk", pdm_clk, 1'b0);
        chk1("init_we", we, 1'b0);
        chk1("init_data_l", data_l, 1'b0);
        chk1("init_data_r", data_r, 1'b0);
        chk1("init_ready", ready, 1'b0);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        session(0, 3, 1'b0);
        session(1, 3, 1'b0);
        session(2, 10, 1'b0);
        session(3, 6, 1'b1);
        repeat (2) @(negedge clk);
        session(3, 4, 1'b0);
        session(4, 8, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL we_missing: %0d strobes outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
